// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a synchronous FIFO onto a valid/ready stream via a 2-entry buffer
// Optional m_last burst flag: FIFO_READER_BURST_LAST_EN
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  word_count,
`ifdef FIFO_READER_BURST_LAST_EN
  output logic              m_last,
`endif
  output logic              idle
);

  logic [1:0]        occ;
  logic [1:0]        occ_after_pop;
  logic [1:0]        occ_next;
  logic [2:0]        committed;
  logic              inflight;
  logic              pop;
  logic [DATA_W-1:0] skid;

  assign pop           = m_valid && m_ready;
  assign occ_after_pop = occ - {1'b0, pop};
  assign occ_next      = occ_after_pop + {1'b0, inflight};
  // Words held plus words already requested must never exceed the two buffer slots.
  assign committed     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en    = !rst && drain_en && !fifo_empty && (committed < 3'd2);
  assign idle          = (occ == 2'd0) && !inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid       <= '0;
      word_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_next;
      m_valid  <= (occ_next != 2'd0);
      if (pop)
        word_count <= word_count + 1'b1;
      // Arriving word lands in the head if the buffer drains this edge, else behind it.
      if (occ_after_pop == 2'd0) begin
        if (inflight)
          m_data <= fifo_dout;
      end else begin
        if (pop)
          m_data <= skid;
        if (inflight)
          skid <= fifo_dout;
      end
    end
  end

`ifdef FIFO_READER_BURST_LAST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BW-1:0] cap_cnt;
  logic          cap_last;
  logic          head_last;
  logic          skid_last;

  // Captures and handshakes occur in the same order, so tagging on capture marks the right handshake.
  assign cap_last = (cap_cnt == BW'(BURST_LEN - 1));
  assign m_last   = m_valid && head_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_cnt   <= '0;
      head_last <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      if (inflight)
        cap_cnt <= cap_last ? '0 : cap_cnt + 1'b1;
      if (occ_after_pop == 2'd0) begin
        if (inflight)
          head_last <= cap_last;
      end else begin
        if (pop)
          head_last <= skid_last;
        if (inflight)
          skid_last <= cap_last;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader with a FIFO model
module tb_fifo_stream_reader;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              drain_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  word_count;
  logic              idle;
`ifdef FIFO_READER_BURST_LAST_EN
  logic              m_last;
`endif

  fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .word_count(word_count),
`ifdef FIFO_READER_BURST_LAST_EN
    .m_last(m_last),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [DATA_W-1:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int hs_idx = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Registered-read FIFO model: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fq[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  task automatic push(input logic [DATA_W-1:0] w);
    fq[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      next_cycle();
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
`ifdef FIFO_READER_BURST_LAST_EN
      if (!m_valid)
        chk("last_when_invalid", m_last, 0);
`endif
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_data, 32'hFFFF_FFFF);
        end else begin
          chk("stream_data", m_data, exp_q.pop_front());
`ifdef FIFO_READER_BURST_LAST_EN
          chk("stream_last", m_last, (hs_idx % 4) == 3);
`endif
          hs_idx++;
        end
      end
    end
  end

  initial begin
    int rd_cnt;
    rst = 1'b1; drain_en = 1'b1; m_ready = 1'b0;

    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #3;
      chk("reset_rd_en", fifo_rd_en, 0);
      chk("reset_valid", m_valid, 0);
      chk("reset_count", word_count, 0);
      chk("reset_idle", idle, 1);
    end
    #1 rst = 1'b0;

    next_cycle();
    drain_en = 1'b0; m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    next_cycle();
    drain_en = 1'b1;
    #1;
    chk("stream_rd_c0", fifo_rd_en, 1);
    chk("stream_valid_c0", m_valid, 0);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #3;
      chk("stream_rd_cn", fifo_rd_en, i < 4);
      chk("stream_valid_cn", m_valid, (i >= 2) && (i <= 5));
    end
    next_cycle(); next_cycle();
    chk("stream_count", word_count, 4);
    chk("stream_idle", idle, 1);

    m_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      if (c >= 2) begin
        chk("bp_valid", m_valid, 1);
        chk("bp_hold", m_data, 8'hB1);
      end
      @(posedge clk); #2;
    end
    chk("bp_rd_pulses", rd_cnt, 2);
    m_ready = 1'b1;
    wait_drain("bp_drain_timeout");
    next_cycle(); next_cycle();
    chk("bp_count", word_count, 8);
    chk("bp_idle", idle, 1);

    push(8'hA5);
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      @(posedge clk); #2;
    end
    chk("guard_rd_pulses", rd_cnt, 1);
    chk("guard_count", word_count, 9);

    drain_en = 1'b0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    next_cycle();
    drain_en = 1'b1;
    #1;
    rd_cnt = fifo_rd_en ? 1 : 0;
    @(posedge clk); #2;
    drain_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      @(posedge clk); #2;
    end
    chk("stop_rd_pulses", rd_cnt, 1);
    chk("stop_fifo_left", wr_ptr - rd_ptr, 3);
    chk("stop_count", word_count, 10);
    chk("stop_idle", idle, 1);
    drain_en = 1'b1;
    wait_drain("stop_drain_timeout");
    next_cycle();
    chk("stop_count_final", word_count, 13);

    rst = 1'b1;
    next_cycle();
    chk("rst_count", word_count, 0);
    hs_idx = 0;
    rst = 1'b0;
    for (int i = 0; i < 17; i++)
      push(8'(i * 3 + 1));
    wait_drain("wrap_drain_timeout");
    next_cycle(); next_cycle();
    chk("wrap_count", word_count, 1);
    chk("wrap_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous FIFO: drains the FIFO's `rd_en`/`empty`/`data_out` port.
- Presents the words on a valid/ready stream to a downstream consumer.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer. Never reads an empty FIFO, never drops or duplicates a word, and sustains 1 word/cycle.
- Sits between `synchronous_fifo` and any stream sink (UART TX, DMA, checker).

Parameters:
- `DATA_W`, 8, width of FIFO data and stream data.
- `CNT_W`, 16, width of the delivered-word counter.
- `BURST_LEN`, 4, words per burst for the optional last-flag feature; must be ≥ 1.

Ports:
- `clk`, input, 1, clock; all logic on rising edge.
- `rst`, input, 1, reset, asynchronous, active-high.
- `drain_en`, input, 1, when high the reader may issue FIFO reads.
- `fifo_empty`, input, 1, FIFO empty flag.
- `fifo_dout`, input, DATA_W, FIFO read data; valid the cycle after `rd_en` was sampled high.
- `fifo_rd_en`, output, 1, FIFO read strobe.
- `m_valid`, output, 1, stream word valid.
- `m_ready`, input, 1, stream sink ready.
- `m_data`, output, DATA_W, stream word.
- `word_count`, output, CNT_W, count of completed stream handshakes.
- `idle`, output, 1, no buffered word and no read in flight.

Behaviour:
- Reset (async assert, sync release):
  - occupancy=0, inflight=0.
  - `m_valid`=0, `m_data`=0, `word_count`=0, `idle`=1, `fifo_rd_en`=0.
- State:
  - `occ` (0..2): words held in the output buffer (2-entry FIFO-order buffer: head/skid).
  - `inflight` (0..1): a read issued last cycle whose data arrives this cycle.
- `pop` = `m_valid` && `m_ready`.
- `fifo_rd_en` (combinational) = `drain_en` && !`fifo_empty` && (`occ` + `inflight` − `pop` < 2).
  - It depends combinationally on `m_ready`; it must not depend on `fifo_dout`.
- `inflight` register: `inflight` <= `fifo_rd_en`.
- Capture: when `inflight`=1, `fifo_dout` is written into the buffer at that edge.
  - Goes to the head if the buffer is empty after this cycle's pop; otherwise to the skid entry.
- `m_valid` = (`occ` != 0); `m_data` = head entry. Both are registered outputs.
- On `pop`, the skid entry advances to head in the same edge.
- Simultaneous `pop` and capture with `occ`=1: the captured word becomes the head; `occ` stays 1.
- Latency: `fifo_rd_en` high in cycle N → word captured at edge N+2 → `m_valid` high in cycle N+2.
- Throughput: with `m_ready` held 1 and FIFO non-empty, one handshake every cycle after the 2-cycle fill.
- Backpressure:
  - With `m_ready`=0, at most 2 words are read: `occ` + `inflight` ≤ 2 always.
  - `m_data` holds stable while `m_valid` && !`m_ready`.
- `drain_en` falling: no new reads. The in-flight word is still captured and buffered words are still delivered.
- `fifo_empty` rising while a read is in flight: that read completes normally.
- `word_count` increments by 1 on every `pop` and wraps 2^CNT_W−1 → 0.
- `idle` = (`occ`==0) && (`inflight`==0).
- Reset mid-transfer: buffered and in-flight words are discarded; the FIFO pop has already happened, which is accepted system-level loss.

Optional Feature:
- Macro `FIFO_READER_BURST_LAST_EN`.
- Defined:
  - Adds output `m_last` (1 bit), carried alongside each buffered word.
  - `m_last`=1 on the word whose handshake completes each group of `BURST_LEN` words; `BURST_LEN`=1 sets `m_last` on every word.
  - The burst counter resets to 0 on `rst` and wraps after `BURST_LEN`.
  - `m_last` is stable under backpressure and is 0 when `m_valid`=0.
- Undefined: no `m_last` port and no burst counter; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles with `fifo_empty`=1, `drain_en`=1.
  - Response: `fifo_rd_en`=0 throughout, `m_valid`=0, `word_count`=0, `idle`=1.
- Streaming:
  - Stimulus: FIFO preloaded with 0x11,0x22,0x33,0x44; `m_ready`=1.
  - Response: `fifo_rd_en` high 4 consecutive cycles; `m_data` 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 2 cycles after the first `rd_en`; `word_count`=4; `idle`=1 at end.
- Backpressure:
  - Stimulus: 4 words queued, `m_ready`=0 for 6 cycles, then 1.
  - Response: exactly 2 `rd_en` pulses during the stall; `m_data`=first word, stable; after release all 4 words arrive in order with no duplicate.
- Empty guard:
  - Stimulus: FIFO holds 1 word (0xA5) then goes empty.
  - Response: exactly 1 `rd_en` pulse; `fifo_rd_en` never high while `fifo_empty`=1; one 0xA5 handshake.
- Drain stop:
  - Stimulus: `drain_en` dropped in the cycle after the first `rd_en`, with 4 words queued.
  - Response: 1 word delivered, no further reads, FIFO retains 3 words.
- Last flag (`FIFO_READER_BURST_LAST_EN`, `BURST_LEN`=4):
  - Stimulus: 8 words streamed.
  - Response: `m_last`=1 only on words 4 and 8.
- Counter wrap:
  - Stimulus: `CNT_W`=4, 17 words.
  - Response: `word_count`=1.
